// File: rtl/ibex_simple_system_pkg.sv
// ----------------------------------------------------------------------------
// ibex_simple_system_pkg
// Shared definitions for the simple system data-memory arbiter slice:
//   - requester index constants (core data port, host/loader port)
//   - requester ID width helper and ID typedef
// No ports (package).
// ----------------------------------------------------------------------------
package ibex_simple_system_pkg;

   // Fixed requester indices on the arbiter's request vectors.
   localparam int unsigned CoreDReq  = 32'd0;
   localparam int unsigned HostReq   = 32'd1;

   // Largest requester count the arbiter is built for.
   localparam int unsigned NumReqMax = 32'd4;

   // Width of a requester ID: $clog2(num_req), but never below one bit.
   function automatic int unsigned req_id_width(input int unsigned num_req);
      if (num_req <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(num_req);
      end
   endfunction

   // Requester ID wide enough for any supported configuration.
   typedef logic [req_id_width(NumReqMax)-1:0] req_id_t;

endpackage

// File: rtl/ibex_simple_system_id_fifo.sv
// ----------------------------------------------------------------------------
// ibex_simple_system_id_fifo
// Small in-order FIFO holding the requester ID of each accepted downstream
// transaction until its response returns.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write push_id_i at the tail (ignored when full)
//   push_id_i      ID to store
//   pop_i          drop the head entry (ignored when empty)
//   head_id_o      ID at the head (oldest outstanding transaction)
//   count_o        number of valid entries
//   full_o/empty_o occupancy flags
// ----------------------------------------------------------------------------
module ibex_simple_system_id_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic [Width-1:0]               push_id_i,
   input  logic                           pop_i,
   output logic [Width-1:0]               head_id_o,
   output logic [$clog2(Depth+1)-1:0]     count_o,
   output logic                           full_o,
   output logic                           empty_o
);

   localparam int unsigned PtrW = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Pointers wrap at Depth, which need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      if (ptr == PtrW'(Depth - 32'd1)) begin
         return {PtrW{1'b0}};
      end else begin
         return ptr + PtrW'(1);
      end
   endfunction

   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   assign full_o    = (count_q == CntW'(Depth));
   assign empty_o   = (count_q == {CntW{1'b0}});
   assign count_o   = count_q;
   assign head_id_o = mem_q[rd_ptr_q];

   // Storage, pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= {Width{1'b0}};
         end
         wr_ptr_q <= {PtrW{1'b0}};
         rd_ptr_q <= {PtrW{1'b0}};
         count_q  <= {CntW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_id_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok_s) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ibex_simple_system_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_simple_system_dmem_arbiter
// Shares the single data-memory slave port between NumReq req/gnt/rvalid
// requesters (index 0 = Ibex data port, index 1 = host/loader).
// Round-robin arbitration; a requester that was presented downstream but not
// granted stays locked as the winner so the downstream address/data remain
// stable. An ID FIFO routes in-order responses back to the issuer.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/we_i/addr_i/be_i/wdata_i  per-requester request channel
//   gnt_o/rvalid_o/err_o          per-requester grant / response / error
//   rdata_o                       shared read data, qualified by rvalid_o
//   dmem_*_o / dmem_*_i           downstream port
//   unexpected_rvalid_o           sticky: response with nothing outstanding
// ----------------------------------------------------------------------------
module ibex_simple_system_dmem_arbiter
   import ibex_simple_system_pkg::*;
#(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]  be_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [DataWidth-1:0]                rdata_o,
   output logic [NumReq-1:0]                   err_o,
   output logic                                dmem_req_o,
   input  logic                                dmem_gnt_i,
   output logic                                dmem_we_o,
   output logic [AddrWidth-1:0]                dmem_addr_o,
   output logic [DataWidth/8-1:0]              dmem_be_o,
   output logic [DataWidth-1:0]                dmem_wdata_o,
   input  logic                                dmem_rvalid_i,
   input  logic [DataWidth-1:0]                dmem_rdata_i,
   input  logic                                dmem_err_i,
   output logic                                unexpected_rvalid_o
);

   localparam int unsigned IdW  = req_id_width(NumReq);
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned BeW  = DataWidth / 8;

   logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
   logic            lock_valid_q, lock_valid_d;
   logic [IdW-1:0]  lock_id_q, lock_id_d;
   logic            unexpected_q, unexpected_d;

   logic [IdW-1:0]  winner_s;
   logic            any_req_s;
   logic            lock_hold_s;
   logic            handshake_s;
   logic            rsp_s;

   logic [IdW-1:0]  fifo_head_s;
   logic [CntW-1:0] fifo_count_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;

   assign any_req_s   = |req_i;
   // A lock only counts while its requester still asserts req; otherwise
   // re-arbitrate in the same cycle.
   assign lock_hold_s = lock_valid_q & req_i[lock_id_q];

   // Winner selection: locked requester first, else round-robin from rr_ptr.
   always_comb begin
      logic          found;
      int unsigned   idx;
      logic [IdW-1:0] idx_w;
      winner_s = {IdW{1'b0}};
      found    = 1'b0;
      idx      = 32'd0;
      idx_w    = {IdW{1'b0}};
      if (lock_hold_s) begin
         winner_s = lock_id_q;
      end else begin
         for (int unsigned i = 0; i < NumReq; i++) begin
            idx   = (32'(rr_ptr_q) + i) % NumReq;
            idx_w = IdW'(idx);
            if (!found && req_i[idx_w]) begin
               winner_s = idx_w;
               found    = 1'b1;
            end else begin
               found    = found;
            end
         end
      end
   end

   // Downstream request is held off whenever the ID FIFO is full; a pop in
   // the same cycle does not release it until the next cycle.
   assign dmem_req_o   = any_req_s & ~fifo_full_s;
   assign handshake_s  = dmem_req_o & dmem_gnt_i;
   assign dmem_we_o    = dmem_req_o & we_i[winner_s];
   assign dmem_addr_o  = dmem_req_o ? addr_i[winner_s]  : {AddrWidth{1'b0}};
   assign dmem_be_o    = dmem_req_o ? be_i[winner_s]    : {BeW{1'b0}};
   assign dmem_wdata_o = dmem_req_o ? wdata_i[winner_s] : {DataWidth{1'b0}};

   assign rsp_s   = dmem_rvalid_i & ~fifo_empty_s;
   assign rdata_o = rsp_s ? dmem_rdata_i : {DataWidth{1'b0}};

   // One-hot grant and response routing.
   always_comb begin
      gnt_o              = {NumReq{1'b0}};
      rvalid_o           = {NumReq{1'b0}};
      err_o              = {NumReq{1'b0}};
      gnt_o[winner_s]    = handshake_s;
      rvalid_o[fifo_head_s] = rsp_s;
      err_o[fifo_head_s] = rsp_s & dmem_err_i;
   end

   // Next-state for round-robin pointer and request lock.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      if (handshake_s) begin
         lock_valid_d = 1'b0;
         if (winner_s == IdW'(NumReq - 32'd1)) begin
            rr_ptr_d = {IdW{1'b0}};
         end else begin
            rr_ptr_d = winner_s + IdW'(1);
         end
      end else if (dmem_req_o) begin
         // Presented but not granted: pin this requester until granted.
         lock_valid_d = 1'b1;
         lock_id_d    = winner_s;
      end else if (lock_valid_q && !lock_hold_s) begin
         lock_valid_d = 1'b0;
      end else begin
         lock_valid_d = lock_valid_q;
      end
   end

   assign unexpected_d        = unexpected_q | (dmem_rvalid_i & (fifo_count_s == {CntW{1'b0}}));
   assign unexpected_rvalid_o = unexpected_q;

   // Arbiter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q     <= {IdW{1'b0}};
         lock_valid_q <= 1'b0;
         lock_id_q    <= {IdW{1'b0}};
         unexpected_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
         unexpected_q <= unexpected_d;
      end
   end

   ibex_simple_system_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdW)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (handshake_s),
      .push_id_i (winner_s),
      .pop_i     (rsp_s),
      .head_id_o (fifo_head_s),
      .count_o   (fifo_count_s),
      .full_o    (fifo_full_s),
      .empty_o   (fifo_empty_s)
   );

endmodule
